// File: rtl/video_tmds_enc.sv
// -----------------------------------------------------------------------------
// video_tmds_enc
//
// DVI 1.0 TMDS encoder for the three video channels feeding the OSER10
// serializers. The block runs in the VDP clock domain and only advances on
// clock edges where the pixel strobe (enable) is high.
//
// Pipeline (each stage advances on an enabled edge):
//   S1  register DE/HS/VS and the three bytes, plus the ones-count of each byte
//   S2  transition-minimised 9-bit q_m and the ones-count of q_m[7:0]
//   S3  running-disparity DC balance (data) or control token (blanking)
// A sample taken at enabled edge E0 is presented on tmds_chN after edge E2.
//
// Ports:
//   clk        VDP clock (42.95454 MHz)
//   reset_n    asynchronous active-low reset; outputs go to 10'h354
//   enable     pixel strobe, high every second clock
//   video_de   active-video flag
//   video_hs   horizontal sync (polarity already applied)
//   video_vs   vertical sync (polarity already applied)
//   video_r/g/b  8-bit colour components
//   tmds_ch0   channel 0 symbol (blue data, or red when swap_rb=1; sync tokens)
//   tmds_ch1   channel 1 symbol (green)
//   tmds_ch2   channel 2 symbol (red data, or blue when swap_rb=1)
//
// Parameter:
//   swap_rb    1 swaps the red and blue data channels; sync stays on channel 0
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module video_tmds_enc #(
    parameter bit swap_rb = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       video_de,
    input  logic       video_hs,
    input  logic       video_vs,
    input  logic [7:0] video_r,
    input  logic [7:0] video_g,
    input  logic [7:0] video_b,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2
);

    localparam logic [9:0] TOKEN_00 = 10'h354;

    // Result of the DC-balance stage for one channel.
    typedef struct packed {
        logic [9:0]        sym;
        logic signed [5:0] cnt;
    } bal_t;

    // Number of ones in a byte.
    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimised word: XNOR chain when the byte is ones-heavy
    // (ties broken by bit 0), XOR chain otherwise. Bit 8 records the choice.
    function automatic logic [8:0] qm_encode(input logic [7:0] d, input logic [3:0] n1);
        logic       use_xnor;
        logic [8:0] qm;
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

    // DC balance: choose whether to invert q_m[7:0] so the running
    // disparity is pulled back toward zero, and update the counter.
    function automatic bal_t dc_balance(input logic [8:0] qm, input logic [3:0] n1,
                                        input logic signed [5:0] cnt);
        bal_t              res;
        logic signed [5:0] diff;
        // N1 - N0 = 2*N1 - 8, range -8..+8.
        diff = $signed({1'b0, n1, 1'b0}) - 6'sd8;
        if ((cnt == 6'sd0) || (n1 == 4'd4)) begin
            res.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            res.cnt = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 6'sd0) && (n1 > 4'd4)) || ((cnt < 6'sd0) && (n1 < 4'd4))) begin
            res.sym = {1'b1, qm[8], ~qm[7:0]};
            res.cnt = cnt - diff + (qm[8] ? 6'sd2 : 6'sd0);
        end else begin
            res.sym = {1'b0, qm[8], qm[7:0]};
            res.cnt = cnt + diff - (qm[8] ? 6'sd0 : 6'sd2);
        end
        return res;
    endfunction

    // Control token for C1C0 during blanking.
    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = 10'h354;
            2'b01:   t = 10'h0AB;
            2'b10:   t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    // ---------------------------------------------------------------- S1
    logic [7:0] w_byte [3];

    assign w_byte[0] = swap_rb ? video_r : video_b;
    assign w_byte[1] = video_g;
    assign w_byte[2] = swap_rb ? video_b : video_r;

    logic       r1_de;
    logic       r1_hs;
    logic       r1_vs;
    logic [7:0] r1_d  [3];
    logic [3:0] r1_n1 [3];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the edge.
    // NOTE: every pipeline register is reset, so after reset the stages hold
    // a clean blanking sample and the outputs keep emitting 10'h354 until
    // real samples have travelled through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1_de <= 1'b0;
            r1_hs <= 1'b0;
            r1_vs <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                r1_d[ch]  <= '0;
                r1_n1[ch] <= '0;
            end
        end else if (enable) begin
            r1_de <= video_de;
            r1_hs <= video_hs;
            r1_vs <= video_vs;
            for (int ch = 0; ch < 3; ch++) begin
                r1_d[ch]  <= w_byte[ch];
                r1_n1[ch] <= ones8(w_byte[ch]);
            end
        end
    end

    // ---------------------------------------------------------------- S2
    logic [8:0] w_qm    [3];
    logic [3:0] w_qm_n1 [3];

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            w_qm[ch]    = qm_encode(r1_d[ch], r1_n1[ch]);
            w_qm_n1[ch] = ones8(w_qm[ch][7:0]);
        end
    end

    logic       r2_de;
    logic       r2_hs;
    logic       r2_vs;
    logic [8:0] r2_qm [3];
    logic [3:0] r2_n1 [3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r2_de <= 1'b0;
            r2_hs <= 1'b0;
            r2_vs <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                r2_qm[ch] <= '0;
                r2_n1[ch] <= '0;
            end
        end else if (enable) begin
            r2_de <= r1_de;
            r2_hs <= r1_hs;
            r2_vs <= r1_vs;
            for (int ch = 0; ch < 3; ch++) begin
                r2_qm[ch] <= w_qm[ch];
                r2_n1[ch] <= w_qm_n1[ch];
            end
        end
    end

    // ---------------------------------------------------------------- S3
    logic signed [5:0] r3_cnt [3];
    logic [9:0]        r3_sym [3];
    bal_t              w_bal  [3];

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            // NOTE: defaults first so every path assigns every bit and no
            // latch is inferred.
            w_bal[ch].sym = TOKEN_00;
            w_bal[ch].cnt = '0;
            if (r2_de) begin
                w_bal[ch] = dc_balance(r2_qm[ch], r2_n1[ch], r3_cnt[ch]);
            end else if (ch == 0) begin
                // Sync rides on channel 0 only: C1 = VS, C0 = HS.
                w_bal[ch].sym = ctrl_token({r2_vs, r2_hs});
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < 3; ch++) begin
                r3_sym[ch] <= TOKEN_00;
                r3_cnt[ch] <= '0;
            end
        end else if (enable) begin
            for (int ch = 0; ch < 3; ch++) begin
                r3_sym[ch] <= w_bal[ch].sym;
                r3_cnt[ch] <= w_bal[ch].cnt;
            end
        end
    end

    assign tmds_ch0 = r3_sym[0];
    assign tmds_ch1 = r3_sym[1];
    assign tmds_ch2 = r3_sym[2];

endmodule
